// File: rtl/axil2wb_pkg.sv
// Shared encodings and constants for the AXI-Lite to Wishbone responder.
package axil2wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB_WR  = 2'd1,
        WB_RD  = 2'd2,
        RD_RSP = 2'd3
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
    localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/axil2wb_wb_timeout.sv
// Wishbone ack watchdog: counts cycles with cyc high and flags expiry after pTIMEOUT.
// Only built when AXIL2WB_TIMEOUT_EN is defined.
`ifdef AXIL2WB_TIMEOUT_EN
module wb_timeout #(
    parameter int pTIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cyc_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CW = (pTIMEOUT < 1) ? 1 : $clog2(pTIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires in the last waiting cycle so cyc drops on the following edge.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (!cyc_i || ack_i) begin
            cnt_d = '0;
        end else begin
            cnt_d    = cnt_q + 1'b1;
            expire_o = (cnt_q == CW'(pTIMEOUT - 1));
        end
    end

endmodule
`endif

// File: rtl/axil2wb.sv
// AXI-Lite responder issuing one Wishbone classic cycle per write/read; write has priority.
// Optional ack timeout enabled with AXIL2WB_TIMEOUT_EN.
module axil2wb
    import axil2wb_pkg::*;
#(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter logic [31:0] pWB_BASE    = 32'h3800_0000,
    parameter int          pTIMEOUT    = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [pDATA_WIDTH-1:0] wbm_dat_o,
    input  logic                   wbm_ack_i,
    input  logic [pDATA_WIDTH-1:0] wbm_dat_i,
    output logic                   err_o
);

    state_e                   state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [31:0]              adr_q, adr_d;
    logic [pDATA_WIDTH-1:0]   dat_q, dat_d;
    logic                     rvalid_q, rvalid_d;
    logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                     aw_acc;
    logic                     ar_acc;
    logic                     timeout;

    assign aw_acc = (state_q == IDLE) && awvalid && wvalid;
    assign ar_acc = (state_q == IDLE) && arvalid && !(awvalid && wvalid);

`ifdef AXIL2WB_TIMEOUT_EN
    logic err_q;

    wb_timeout #(
        .pTIMEOUT (pTIMEOUT)
    ) u_wb_timeout (
        .clk_i    (axis_clk),
        .rst_ni   (axis_rst_n),
        .cyc_i    (cyc_q),
        .ack_i    (wbm_ack_i),
        .expire_o (timeout)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (aw_acc) begin
                    adr_d   = pWB_BASE | 32'(awaddr);
                    dat_d   = wdata;
                    we_d    = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = WB_WR;
                end else if (ar_acc) begin
                    adr_d   = pWB_BASE | 32'(araddr);
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = WB_RD;
                end
            end
            WB_WR: begin
                if (wbm_ack_i || timeout) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            WB_RD: begin
                // A timed-out read still answers the initiator, with all-ones data.
                if (wbm_ack_i) begin
                    rdata_d  = wbm_dat_i;
                    rvalid_d = 1'b1;
                    cyc_d    = 1'b0;
                    state_d  = RD_RSP;
                end else if (timeout) begin
                    rdata_d  = pDATA_WIDTH'(RD_ERR_DATA);
                    rvalid_d = 1'b1;
                    cyc_d    = 1'b0;
                    state_d  = RD_RSP;
                end
            end
            RD_RSP: begin
                if (rvalid_q && rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign awready   = aw_acc;
    assign wready    = aw_acc;
    assign arready   = ar_acc;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = cyc_q ? WB_SEL_ALL : 4'h0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_axil2wb.sv
// Scoreboard bench for axil2wb: stimulus queues expected Wishbone cycles and read data,
// a monitor pops and compares them as the DUT presents them.
module tb_axil2wb;

    logic        clk;
    logic        rst_n;
    logic        awvalid, wvalid, arvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata;
    logic        awready, wready, arready, rvalid;
    logic [31:0] rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        err_o;

    axil2wb #(
        .pADDR_WIDTH (12),
        .pDATA_WIDTH (32),
        .pWB_BASE    (32'h3800_0000),
        .pTIMEOUT    (8)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [31:0] rd_q[$];

    int nvec  = 0;
    int nfail = 0;

    // slave controls and monitor observations
    int          slave_delay = 0;
    logic        slave_never = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          last_cyc_len = 0;
    int          aw_hi_cnt = 0;
    int          err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks after slave_delay cycles of cyc, or never.
    initial begin
        int s_cnt;
        s_cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && !slave_never && s_cnt == slave_delay) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = slave_rdata;
            end else begin
                wbm_ack_i = 1'b0;
            end
            if (wbm_cyc_o) s_cnt++;
            else s_cnt = 0;
        end
    end

    // Monitor: compares each new Wishbone cycle and each R handshake against the queues.
    initial begin
        logic cyc_prev;
        int   cyc_len;
        wb_exp_t e;
        logic [31:0] r;
        cyc_prev = 1'b0;
        cyc_len  = 0;
        forever begin
            @(negedge clk);
            if (awready) aw_hi_cnt++;
            if (err_o) err_cnt++;
            if (wbm_cyc_o && !cyc_prev) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected_cycle", 32'd1, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_we", {31'd0, wbm_we_o}, {31'd0, e.we});
                    chk("wb_adr", wbm_adr_o, e.adr);
                    chk("wb_sel", {28'd0, wbm_sel_o}, 32'hF);
                    chk("wb_stb", {31'd0, wbm_stb_o}, 32'd1);
                    if (e.we) chk("wb_dat", wbm_dat_o, e.dat);
                end
            end
            if (wbm_cyc_o) cyc_len++;
            else if (cyc_prev) begin
                last_cyc_len = cyc_len;
                cyc_len = 0;
            end else cyc_len = 0;
            cyc_prev = wbm_cyc_o;
            if (rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_data", rdata, r);
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [31:0] exp_adr);
        int n;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        wb_q.push_back('{we: 1'b1, adr: exp_adr, dat: d});
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) chk("write_handshake_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp_adr,
                            input logic [31:0] exp_data, input logic exp_rsp);
        int n;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        wb_q.push_back('{we: 1'b0, adr: exp_adr, dat: 32'h0});
        if (exp_rsp) rd_q.push_back(exp_data);
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) chk("read_handshake_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wbm_cyc_o || rvalid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {24'd0, awready, wready, arready, rvalid,
                            wbm_cyc_o, wbm_stb_o, wbm_we_o, err_o}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_adr"}, wbm_adr_o, 32'd0);
        chk({tag, "_dat"}, wbm_dat_o, 32'd0);
        chk({tag, "_sel"}, {28'd0, wbm_sel_o}, 32'd0);
    endtask

    initial begin
        int aw0, lat, n, e0;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
        awaddr = 12'h0; araddr = 12'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single write, ack after 3 extra cycles
        slave_delay = 3;
        aw0 = aw_hi_cnt;
        axi_write(12'h010, 32'h1234_5678, 32'h3800_0010);
        wait_idle();
        chk("wr_cyc_len", last_cyc_len, 32'd4);
        chk("wr_awready_cycles", aw_hi_cnt - aw0, 32'd1);

        // single read with response stall
        slave_delay = 0;
        slave_rdata = 32'h0000_0004;
        rready = 1'b0;
        axi_read(12'h000, 32'h3800_0000, 32'h0000_0004, 1'b1);
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_latency", lat, 32'd2);
        chk("rd_cyc_len", last_cyc_len, 32'd1);
        arvalid = 1'b1; araddr = 12'h004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_hold_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rd_hold_rdata", rdata, 32'h0000_0004);
            chk("rd_hold_no_arready", {31'd0, arready}, 32'd0);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_idle();

        // write and read presented together: write first
        slave_delay = 1;
        slave_rdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h100; wdata = 32'h0BAD_CAFE;
        arvalid = 1'b1; araddr = 12'h200;
        wb_q.push_back('{we: 1'b1, adr: 32'h3800_0100, dat: 32'h0BAD_CAFE});
        wb_q.push_back('{we: 1'b0, adr: 32'h3800_0200, dat: 32'h0});
        rd_q.push_back(32'hA5A5_0001);
        #1;
        chk("coll_awready", {31'd0, awready}, 32'd1);
        chk("coll_arready_blocked", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("coll_arready_delay", n, 32'd3);
        chk("coll_cyc_low_at_arready", {31'd0, wbm_cyc_o}, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_idle();

        // split write channels
        slave_delay = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b0; awaddr = 12'h0FC; wdata = 32'h8765_4321;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("split_no_hs", {30'd0, awready, wready}, 32'd0);
            chk("split_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        wb_q.push_back('{we: 1'b1, adr: 32'h3800_00FC, dat: 32'h8765_4321});
        #1;
        chk("split_hs", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_idle();

        // reset while cyc is high
        slave_never = 1'b1;
        axi_write(12'h020, 32'hCAFE_F00D, 32'h3800_0020);
        @(negedge clk);
        chk("rst_wr_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_wr");
        @(posedge clk); #1;
        slave_never = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset while a read response is pending
        rready = 1'b0;
        slave_rdata = 32'h0000_0055;
        axi_read(12'h030, 32'h3800_0030, 32'h0, 1'b0);
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_rd_pending", {31'd0, rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_rd");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rready = 1'b1;
        slave_rdata = 32'hDEAD_BEEF;
        axi_read(12'hABC, 32'h3800_0ABC, 32'hDEAD_BEEF, 1'b1);
        wait_idle();

`ifdef AXIL2WB_TIMEOUT_EN
        // read that is never acked
        slave_never = 1'b1;
        e0 = err_cnt;
        axi_read(12'h040, 32'h3800_0040, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("to_cyc_len", last_cyc_len, 32'd8);
        chk("to_err_pulses", err_cnt - e0, 32'd1);
        slave_never = 1'b0;
`else
        e0 = err_cnt;
        chk("err_never_pulses", e0, 32'd0);
`endif

        n = 0;
        while ((wb_q.size() != 0 || rd_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil2wb.md
# axil2wb

AXI-Lite responder that turns each single-beat AXI-Lite write or read into one Wishbone classic master cycle. It sits between an AXI-Lite initiator (the Wishbone-to-AXI bridge or the FIR control path) and the user-project Wishbone fabric, so AXI-side logic can reach Wishbone-mapped registers and exmem. Only one transaction is outstanding at a time. If both a write and a read are presented in the same cycle, the write wins.

## Interface
Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, data width (AXI and Wishbone)
- pWB_BASE, 32'h3800_0000, Wishbone base OR-ed with the zero-extended AXI address
- pTIMEOUT, 255, maximum number of Wishbone cycles to wait for ack (timeout build only)

Ports:
- axis_clk  in  1  single clock for the whole block
- axis_rst_n  in  1  asynchronous reset, active-low
- awvalid  in  1 / awready  out  1 / awaddr  in  pADDR_WIDTH  write address channel
- wvalid  in  1 / wready  out  1 / wdata  in  pDATA_WIDTH  write data channel
- arvalid  in  1 / arready  out  1 / araddr  in  pADDR_WIDTH  read address channel
- rvalid  out  1 / rready  in  1 / rdata  out  pDATA_WIDTH  read data channel
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe and write enable
- wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
- wbm_adr_o  out  32 / wbm_dat_o  out  pDATA_WIDTH  Wishbone address and write data
- wbm_ack_i  in  1 / wbm_dat_i  in  pDATA_WIDTH  Wishbone acknowledge and read data
- err_o  out  1  one-cycle pulse when a timeout occurs (timeout build only; otherwise tied 0)

## Operation
- States: IDLE, WB_WR, WB_RD, RD_RSP.
- **Accepting a write (IDLE):**
  - The block accepts a write only when awvalid and wvalid are both high.
  - awready = wready = (IDLE & awvalid & wvalid), combinational, so both channels handshake in the same cycle.
  - A lone awvalid or a lone wvalid is never accepted.
- **Accepting a read (IDLE):** arready = (IDLE & arvalid & ~(awvalid & wvalid)), combinational.
- **Latching:** on the accepting edge, register wbm_adr_o = pWB_BASE | addr, wbm_dat_o = wdata (writes only), wbm_we_o, and set wbm_cyc_o = wbm_stb_o = 1. Then enter WB_WR or WB_RD.
- **WB_WR:** cyc, stb, adr and dat hold until wbm_ack_i is sampled high. On that edge, cyc, stb and we clear and the state returns to IDLE. There is no B channel: a write is complete at ack.
- **WB_RD:** on the edge where ack is sampled, rdata <= wbm_dat_i, rvalid <= 1, cyc/stb clear, and the state moves to RD_RSP.
- **RD_RSP:**
  - rvalid and rdata hold until rready is high.
  - rvalid clears on the edge where rvalid & rready, and the state returns to IDLE.
  - rready is ignored while rvalid is 0.
- **Ignored inputs:** wbm_ack_i is ignored unless cyc is high. AXI valids arriving outside IDLE are not acknowledged and must be held by the initiator.

## Timing
- **Reset values:** every output is 0 on reset (awready, wready, arready, rvalid, rdata, all wbm_*, err_o); state is IDLE. Reset takes effect immediately, including mid-cycle: cyc drops at once, and any pending read response is discarded.
- **Write latency:** handshake at edge T, cyc asserted T to T+1. With ack combinational in the same cycle, cyc drops at T+2, so the block can accept again at T+2. Back-to-back throughput is one transaction per 2 cycles.
- **Read latency:** handshake at T, ack in cycle T+1, rvalid high from T+2. With rready high, rvalid drops at T+3.
- The address is zero-extended from pADDR_WIDTH to 32 bits before the OR with pWB_BASE.

## Configuration
- Macro: AXIL2WB_TIMEOUT_EN.
- **Defined:**
  - A counter runs while cyc is high and clears on ack.
  - If ack has not arrived after pTIMEOUT cycles, cyc/stb drop on the next edge and err_o pulses for one cycle.
  - A timed-out write returns to IDLE.
  - A timed-out read enters RD_RSP with rdata = 32'hFFFF_FFFF.
- **Undefined:** no counter is built; the block waits for ack indefinitely and err_o is constant 0.

## Structure
- Package axil2wb_pkg holds:
  - state encoding (IDLE=0, WB_WR=1, WB_RD=2, RD_RSP=3)
  - WB_SEL_ALL = 4'hF
  - RD_ERR_DATA = 32'hFFFF_FFFF
- Sub-module wb_timeout (counter, compare against pTIMEOUT, expiry pulse) is instantiated only when AXIL2WB_TIMEOUT_EN is defined.

## Test plan
- **Single write:** awaddr=12'h010, wdata=32'h1234_5678, ack delayed 3 cycles → Wishbone cycle with wbm_adr_o=32'h3800_0010, wbm_dat_o=32'h1234_5678, we=1, sel=4'hF; cyc held exactly 4 cycles; awready/wready high for one cycle only.
- **Single read:** araddr=12'h000, slave returns 32'h0000_0004 with ack in the first cyc cycle → rvalid at T+2 with rdata=32'h4. With rready held low for 5 cycles, rvalid and rdata stay stable and no new arready is given.
- **Write/read collision:** awvalid, wvalid and arvalid all high at once → the write is served first, arready is granted only after the write's ack, and two Wishbone cycles are issued in order (we=1, then we=0).
- **Split write channels:** awvalid high with wvalid low for 4 cycles → no handshake and no cyc. Raising wvalid gives the handshake on that cycle.
- **Reset mid-operation:** assert axis_rst_n=0 while cyc is high, or while rvalid is pending → all outputs 0 immediately; after release the block is in IDLE and accepts a fresh read correctly.
- **Timeout (with AXIL2WB_TIMEOUT_EN, pTIMEOUT=8):** read, never ack → cyc drops after 8 cycles, err_o pulses once, rdata=32'hFFFF_FFFF with rvalid.
